brick_field_renderer: RTL and testbench

Second-generation screen renderer for the breakout game. It draws the housing, paddle and ball, plus a parametrised field of destructible bricks held in an on-chip alive-bitmap. Game logic clears bricks through a valid/ready hit handshake that is only accepted during vertical blank. It sits between the game-logic FSM and the SVGA interface, consuming X_PIXEL/Y_PIXEL and producing a registered COLOR.

---
 rtl/brick_field_renderer.sv | 151 +++++++++++++++
 tb/tb_brick_field_renderer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/brick_field_renderer.sv
// Breakout screen renderer: housing, paddle, ball and a field of destructible bricks.
// Optional build macro BRICK_ROW_COLOR_EN selects a per-row brick palette instead of white bricks.
module brick_field_renderer #(
  parameter int BRICK_ROWS          = 6,
  parameter int BRICK_COLS          = 14,
  parameter int ROW_W               = 3,
  parameter int COL_W               = 4,
  parameter int CNT_W               = 7,
  parameter int BRICK_W_TILES       = 7,
  parameter int BRICK_H_TILES       = 2,
  parameter int FIELD_X_TILE        = 1,
  parameter int FIELD_Y_TILE        = 12,
  parameter int CEILING_Y_TILE      = 9,
  parameter int LEFT_WALL_X_TILE    = 0,
  parameter int RIGHT_WALL_X_TILE   = 99,
  parameter int PADDLE_Y_TILE       = 73,
  parameter int PADDLE_LENGTH_PIXEL = 60,
  parameter int BALL_SIZE_PIXEL     = 8,
  parameter int SCREEN_HEIGHT       = 600
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [9:0]       X_PIXEL,
  input  logic [9:0]       Y_PIXEL,
  input  logic [9:0]       PADDLE_X_PIXEL,
  input  logic [9:0]       BALL_X_PIXEL,
  input  logic [9:0]       BALL_Y_PIXEL,
  input  logic             NEW_LEVEL,
  input  logic             HIT_VALID,
  input  logic [ROW_W-1:0] HIT_ROW,
  input  logic [COL_W-1:0] HIT_COL,
  output logic             HIT_READY,
  output logic             HIT_ACK,
  output logic             HIT_LIVE,
  output logic [CNT_W-1:0] BRICKS_LEFT,
  output logic             LEVEL_CLEAR,
  output logic             FRAME_DONE,
  output logic [7:0]       COLOR
);

  localparam int NBRICK = BRICK_ROWS * BRICK_COLS;
  localparam int IDX_W  = (NBRICK > 1) ? $clog2(NBRICK) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBRICK);

`ifdef BRICK_ROW_COLOR_EN
  function automatic logic [7:0] brick_color(input logic [2:0] r);
    case (r)
      3'd0:    brick_color = 8'hE0;
      3'd1:    brick_color = 8'hEC;
      3'd2:    brick_color = 8'hFC;
      3'd3:    brick_color = 8'h1C;
      3'd4:    brick_color = 8'h1F;
      3'd5:    brick_color = 8'h03;
      3'd6:    brick_color = 8'hE3;
      default: brick_color = 8'hFF;
    endcase
  endfunction
`endif

  logic [NBRICK-1:0] alive;
  logic [CNT_W-1:0]  bricks_left, cnt_next;
  logic              hit_ack_p0, hit_live_p0, level_clear_p0, frame_done_p0;
  logic [7:0]        color_p0, pix_color, brick_rgb;

  int               xi, yi, xt, yt, col, row, xoff, yoff;
  logic             in_field, mortar, brick_on, housing, paddle, ball;
  logic [IDX_W-1:0] bidx;

  // Brick column/row found by walking the tile boundaries of each brick edge
  always_comb begin
    xi   = int'(X_PIXEL);
    yi   = int'(Y_PIXEL);
    xt   = int'(X_PIXEL[9:3]);
    yt   = int'(Y_PIXEL[9:3]);
    col  = 0;
    row  = 0;
    for (int c = 1; c < BRICK_COLS; c++)
      if (xt >= FIELD_X_TILE + c * BRICK_W_TILES) col = c;
    for (int r = 1; r < BRICK_ROWS; r++)
      if (yt >= FIELD_Y_TILE + r * BRICK_H_TILES) row = r;
    xoff     = xi - (FIELD_X_TILE + col * BRICK_W_TILES) * 8;
    yoff     = yi - (FIELD_Y_TILE + row * BRICK_H_TILES) * 8;
    in_field = (xt >= FIELD_X_TILE) && (xt < FIELD_X_TILE + BRICK_COLS * BRICK_W_TILES) &&
               (yt >= FIELD_Y_TILE) && (yt < FIELD_Y_TILE + BRICK_ROWS * BRICK_H_TILES);
    mortar   = (xoff == BRICK_W_TILES * 8 - 1) || (yoff == BRICK_H_TILES * 8 - 1);
    bidx     = in_field ? IDX_W'(row * BRICK_COLS + col) : '0;
    brick_on = in_field && !mortar && alive[bidx];
`ifdef BRICK_ROW_COLOR_EN
    brick_rgb = brick_color(row[2:0]);
`else
    brick_rgb = 8'hFF;
`endif
    housing = (yt == CEILING_Y_TILE) ||
              ((yt > CEILING_Y_TILE) && ((xt == LEFT_WALL_X_TILE) || (xt == RIGHT_WALL_X_TILE)));
    paddle  = (yt == PADDLE_Y_TILE) && (xi >= int'(PADDLE_X_PIXEL)) &&
              (xi < int'(PADDLE_X_PIXEL) + PADDLE_LENGTH_PIXEL);
    ball    = (xi >= int'(BALL_X_PIXEL)) && (xi < int'(BALL_X_PIXEL) + BALL_SIZE_PIXEL) &&
              (yi >= int'(BALL_Y_PIXEL)) && (yi < int'(BALL_Y_PIXEL) + BALL_SIZE_PIXEL);
    if (ball || paddle || housing) pix_color = 8'hFF;
    else if (brick_on)             pix_color = brick_rgb;
    else                           pix_color = 8'h00;
  end

  int               hr, hc;
  logic             hit_in_range, hit_accept, hit_live_now;
  logic [IDX_W-1:0] hidx;

  // Hit lookup; out-of-range targets are acknowledged but never touch the bitmap
  always_comb begin
    hr           = int'(HIT_ROW);
    hc           = int'(HIT_COL);
    hit_in_range = (hr < BRICK_ROWS) && (hc < BRICK_COLS);
    hidx         = hit_in_range ? IDX_W'(hr * BRICK_COLS + hc) : '0;
    HIT_READY    = (int'(Y_PIXEL) >= SCREEN_HEIGHT) && !NEW_LEVEL && RESET_N;
    hit_accept   = HIT_VALID && HIT_READY;
    hit_live_now = hit_accept && hit_in_range && alive[hidx];
    if (NEW_LEVEL)         cnt_next = FULL_CNT;
    else if (hit_live_now) cnt_next = bricks_left - CNT_W'(1);
    else                   cnt_next = bricks_left;
  end

  // Stage p0: registered colour, frame sync and hit response
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      alive          <= '1;
      bricks_left    <= FULL_CNT;
      hit_ack_p0     <= 1'b0;
      hit_live_p0    <= 1'b0;
      level_clear_p0 <= 1'b0;
      frame_done_p0  <= 1'b0;
      color_p0       <= 8'h00;
    end else begin
      hit_ack_p0     <= hit_accept;
      hit_live_p0    <= hit_live_now;
      bricks_left    <= cnt_next;
      level_clear_p0 <= (cnt_next == '0);
      frame_done_p0  <= (X_PIXEL == 10'd0) && (int'(Y_PIXEL) == SCREEN_HEIGHT);
      color_p0       <= pix_color;
      if (NEW_LEVEL)         alive       <= '1;
      else if (hit_live_now) alive[hidx] <= 1'b0;
    end
  end

  assign HIT_ACK     = hit_ack_p0;
  assign HIT_LIVE    = hit_live_p0;
  assign BRICKS_LEFT = bricks_left;
  assign LEVEL_CLEAR = level_clear_p0;
  assign FRAME_DONE  = frame_done_p0;
  assign COLOR       = color_p0;

endmodule

// File: tb/tb_brick_field_renderer.sv
// Directed bench for brick_field_renderer: colour vector table plus hit/level/frame sequences.
module tb_brick_field_renderer;

`ifdef BRICK_ROW_COLOR_EN
  localparam logic [7:0] BC0 = 8'hE0;
  localparam logic [7:0] BC1 = 8'hEC;
`else
  localparam logic [7:0] BC0 = 8'hFF;
  localparam logic [7:0] BC1 = 8'hFF;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [9:0] X_PIXEL, Y_PIXEL, PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
  logic       NEW_LEVEL, HIT_VALID;
  logic [2:0] HIT_ROW;
  logic [3:0] HIT_COL;
  logic       HIT_READY, HIT_ACK, HIT_LIVE, LEVEL_CLEAR, FRAME_DONE;
  logic [6:0] BRICKS_LEFT;
  logic [7:0] COLOR;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  brick_field_renderer dut (
    .CLK(CLK), .RESET_N(RESET_N), .X_PIXEL(X_PIXEL), .Y_PIXEL(Y_PIXEL),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL),
    .NEW_LEVEL(NEW_LEVEL), .HIT_VALID(HIT_VALID), .HIT_ROW(HIT_ROW), .HIT_COL(HIT_COL),
    .HIT_READY(HIT_READY), .HIT_ACK(HIT_ACK), .HIT_LIVE(HIT_LIVE), .BRICKS_LEFT(BRICKS_LEFT),
    .LEVEL_CLEAR(LEVEL_CLEAR), .FRAME_DONE(FRAME_DONE), .COLOR(COLOR)
  );

  typedef struct {
    string      name;
    logic [9:0] x, y, bx, by;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic scan(input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] bx, input logic [9:0] by);
    X_PIXEL = x; Y_PIXEL = y; BALL_X_PIXEL = bx; BALL_Y_PIXEL = by;
    cyc();
  endtask

  task automatic do_hit(input string nm, input int r, input int c,
                        input logic exp_live, input int exp_cnt);
    X_PIXEL = 10'd100; Y_PIXEL = 10'd600;
    HIT_ROW = 3'(r); HIT_COL = 4'(c); HIT_VALID = 1'b1;
    #1;
    chk({nm, "_ready"}, 32'(HIT_READY), 32'd1);
    @(posedge CLK); #1;
    HIT_VALID = 1'b0;
    chk({nm, "_ack"}, 32'(HIT_ACK), 32'd1);
    chk({nm, "_live"}, 32'(HIT_LIVE), 32'(exp_live));
    chk({nm, "_cnt"}, 32'(BRICKS_LEFT), 32'(exp_cnt));
  endtask

  task automatic quiet_hit(input int r, input int c);
    X_PIXEL = 10'd100; Y_PIXEL = 10'd600;
    HIT_ROW = 3'(r); HIT_COL = 4'(c); HIT_VALID = 1'b1;
    cyc();
    HIT_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"brick00",      10'd8,   10'd96,  10'd1000, 10'd1000, BC0});
    vecs.push_back('{"mortar_x",     10'd63,  10'd96,  10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"mortar_y",     10'd8,   10'd111, 10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"row1",         10'd8,   10'd112, 10'd1000, 10'd1000, BC1});
    vecs.push_back('{"col1",         10'd64,  10'd96,  10'd1000, 10'd1000, BC0});
    vecs.push_back('{"col13",        10'd790, 10'd96,  10'd1000, 10'd1000, BC0});
    vecs.push_back('{"col13_mortar", 10'd791, 10'd96,  10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"above_field",  10'd8,   10'd95,  10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"below_field",  10'd400, 10'd192, 10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"ceiling",      10'd400, 10'd72,  10'd1000, 10'd1000, 8'hFF});
    vecs.push_back('{"left_wall",    10'd0,   10'd80,  10'd1000, 10'd1000, 8'hFF});
    vecs.push_back('{"right_wall",   10'd792, 10'd200, 10'd1000, 10'd1000, 8'hFF});
    vecs.push_back('{"wall_high",    10'd0,   10'd64,  10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"paddle_l",     10'd500, 10'd584, 10'd1000, 10'd1000, 8'hFF});
    vecs.push_back('{"paddle_r",     10'd559, 10'd584, 10'd1000, 10'd1000, 8'hFF});
    vecs.push_back('{"paddle_end",   10'd560, 10'd584, 10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"paddle_pre",   10'd499, 10'd584, 10'd1000, 10'd1000, 8'h00});
    vecs.push_back('{"ball_tl",      10'd400, 10'd300, 10'd400,  10'd300,  8'hFF});
    vecs.push_back('{"ball_br",      10'd407, 10'd307, 10'd400,  10'd300,  8'hFF});
    vecs.push_back('{"ball_xend",    10'd408, 10'd300, 10'd400,  10'd300,  8'h00});
    vecs.push_back('{"ball_yend",    10'd400, 10'd308, 10'd400,  10'd300,  8'h00});

    RESET_N = 1'b0; NEW_LEVEL = 1'b0; HIT_VALID = 1'b0; HIT_ROW = '0; HIT_COL = '0;
    X_PIXEL = 10'd100; Y_PIXEL = 10'd300; PADDLE_X_PIXEL = 10'd500;
    BALL_X_PIXEL = 10'd1000; BALL_Y_PIXEL = 10'd1000;
    cyc(); cyc();
    chk("rst_color", 32'(COLOR), 32'h00);
    chk("rst_cnt", 32'(BRICKS_LEFT), 32'd84);
    chk("rst_ack", 32'(HIT_ACK), 32'd0);
    chk("rst_lc", 32'(LEVEL_CLEAR), 32'd0);
    chk("rst_fd", 32'(FRAME_DONE), 32'd0);
    chk("rst_ready", 32'(HIT_READY), 32'd0);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      scan(vecs[i].x, vecs[i].y, vecs[i].bx, vecs[i].by);
      chk(vecs[i].name, 32'(COLOR), 32'(vecs[i].exp));
    end
    BALL_X_PIXEL = 10'd1000; BALL_Y_PIXEL = 10'd1000;

    do_hit("hit00", 0, 0, 1'b1, 83);
    cyc();
    chk("ack_pulse", 32'(HIT_ACK), 32'd0);
    scan(10'd8, 10'd96, 10'd1000, 10'd1000);
    chk("dead00", 32'(COLOR), 32'h00);
    scan(10'd64, 10'd96, 10'd1000, 10'd1000);
    chk("alive01", 32'(COLOR), 32'(BC0));
    do_hit("rehit00", 0, 0, 1'b0, 83);
    do_hit("row7", 7, 0, 1'b0, 83);
    do_hit("col14", 0, 14, 1'b0, 83);

    // Request held during active video must wait for vertical blank
    X_PIXEL = 10'd100; Y_PIXEL = 10'd300; HIT_ROW = 3'd1; HIT_COL = 4'd1; HIT_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("held_ready", 32'(HIT_READY), 32'd0);
      cyc();
      chk("held_noack", 32'(HIT_ACK), 32'd0);
    end
    Y_PIXEL = 10'd600;
    cyc();
    HIT_VALID = 1'b0;
    chk("held_ack", 32'(HIT_ACK), 32'd1);
    chk("held_live", 32'(HIT_LIVE), 32'd1);
    chk("held_cnt", 32'(BRICKS_LEFT), 32'd82);

    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 14; c++)
        quiet_hit(r, c);
    chk("clear_cnt", 32'(BRICKS_LEFT), 32'd0);
    chk("clear_lc", 32'(LEVEL_CLEAR), 32'd1);

    X_PIXEL = 10'd100; Y_PIXEL = 10'd600; HIT_ROW = 3'd0; HIT_COL = 4'd1;
    HIT_VALID = 1'b1; NEW_LEVEL = 1'b1;
    #1;
    chk("nl_ready", 32'(HIT_READY), 32'd0);
    cyc();
    HIT_VALID = 1'b0; NEW_LEVEL = 1'b0;
    chk("nl_noack", 32'(HIT_ACK), 32'd0);
    chk("nl_cnt", 32'(BRICKS_LEFT), 32'd84);
    chk("nl_lc", 32'(LEVEL_CLEAR), 32'd0);
    scan(10'd64, 10'd96, 10'd1000, 10'd1000);
    chk("nl_refill01", 32'(COLOR), 32'(BC0));
    scan(10'd8, 10'd96, 10'd8, 10'd96);
    chk("ball_on_brick", 32'(COLOR), 32'hFF);
    scan(10'd16, 10'd96, 10'd8, 10'd96);
    chk("ball_xedge_brick", 32'(COLOR), 32'(BC0));
    BALL_X_PIXEL = 10'd1000; BALL_Y_PIXEL = 10'd1000;

    X_PIXEL = 10'd0; Y_PIXEL = 10'd600;
    cyc();
    chk("fd_high", 32'(FRAME_DONE), 32'd1);
    X_PIXEL = 10'd1;
    cyc();
    chk("fd_low", 32'(FRAME_DONE), 32'd0);
    X_PIXEL = 10'd0; Y_PIXEL = 10'd599;
    cyc();
    chk("fd_y599", 32'(FRAME_DONE), 32'd0);

    do_hit("hit22", 2, 2, 1'b1, 83);
    X_PIXEL = 10'd100; Y_PIXEL = 10'd600; HIT_ROW = 3'd3; HIT_COL = 4'd3;
    HIT_VALID = 1'b1; RESET_N = 1'b0;
    #1;
    chk("rst_hs_ready", 32'(HIT_READY), 32'd0);
    cyc();
    HIT_VALID = 1'b0; RESET_N = 1'b1;
    chk("rst_hs_ack", 32'(HIT_ACK), 32'd0);
    chk("rst_hs_cnt", 32'(BRICKS_LEFT), 32'd84);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
